// File: rtl/rotary_quadrature_gen.sv
// Quadrature A/B generator emulating a detented rotary encoder; one detent cycle per queued step.
// Optional contact-bounce emulation on every phase transition: define ROTARY_GEN_BOUNCE_EN.
module rotary_quadrature_gen #(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned PEND_W       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step_inc,
    input  logic                     step_dec,
    output logic                     rotary_a,
    output logic                     rotary_b,
    output logic                     busy,
    output logic signed [PEND_W-1:0] pending,
    output logic                     overflow
);

    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic signed [PEND_W:0] P_ONE = (PEND_W+1)'(1);
    localparam logic signed [PEND_W:0] PMAX  = (PEND_W+1)'((2 ** (PEND_W - 1)) - 1);

    typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, PH4} state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_dir_inc;
    logic [1:0]                r_ab;
    logic                      r_busy;
    logic signed [PEND_W-1:0]  r_pending;
    logic                      r_overflow;

    logic                      w_start;
    logic signed [PEND_W:0]    w_pend_ext;
    logic signed [PEND_W:0]    w_sum;
    logic signed [PEND_W-1:0]  w_pend_next;
    logic                      w_overflow;

    // {a,b} level held during each phase; increment runs 01,11,10,00, decrement 10,11,01,00
    function automatic logic [1:0] phase_ab(input state_t s, input logic dir_inc);
        case (s)
            PH1:     return dir_inc ? 2'b01 : 2'b10;
            PH2:     return 2'b11;
            PH3:     return dir_inc ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic state_t next_phase(input state_t s);
        case (s)
            PH1:     return PH2;
            PH2:     return PH3;
            PH3:     return PH4;
            default: return IDLE;
        endcase
    endfunction

`ifdef ROTARY_GEN_BOUNCE_EN
    // Level of the previous phase, used as the "old" value while the changing line chatters
    function automatic logic [1:0] prev_ab(input state_t s, input logic dir_inc);
        case (s)
            PH2:     return phase_ab(PH1, dir_inc);
            PH3:     return phase_ab(PH2, dir_inc);
            PH4:     return phase_ab(PH3, dir_inc);
            default: return 2'b00;
        endcase
    endfunction
`endif

    // Pending queue: start-commit and new request combine, then saturate symmetrically
    always_comb begin
        w_start     = (r_state == IDLE) && (r_pending != '0);
        w_pend_ext  = {r_pending[PEND_W-1], r_pending};
        w_sum       = w_pend_ext;
        w_overflow  = 1'b0;
        if (w_start) begin
            w_sum = w_pend_ext[PEND_W] ? (w_pend_ext + P_ONE) : (w_pend_ext - P_ONE);
        end
        if (step_inc && !step_dec) begin
            w_sum = w_sum + P_ONE;
        end else if (step_dec && !step_inc) begin
            w_sum = w_sum - P_ONE;
        end
        w_pend_next = w_sum[PEND_W-1:0];
        if (w_sum > PMAX) begin
            w_pend_next = PMAX[PEND_W-1:0];
            w_overflow  = 1'b1;
        end else if (w_sum < -PMAX) begin
            w_pend_next = (-PMAX);
            w_overflow  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dir_inc  <= 1'b0;
            r_ab       <= 2'b00;
            r_busy     <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= w_pend_next;
            r_overflow <= w_overflow;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state   <= PH1;
                        r_cnt     <= '0;
                        r_dir_inc <= ~r_pending[PEND_W-1];
                        r_ab      <= phase_ab(PH1, ~r_pending[PEND_W-1]);
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_state == PH4) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_ab    <= 2'b00;
                        end else begin
                            r_state <= next_phase(r_state);
                            r_ab    <= phase_ab(next_phase(r_state), r_dir_inc);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
`ifdef ROTARY_GEN_BOUNCE_EN
                        // Phase cycles 1 and 3 revert to the old level: new,old,new,old,new
                        if (r_cnt == CNT_W'(0) || r_cnt == CNT_W'(2)) begin
                            r_ab <= prev_ab(r_state, r_dir_inc);
                        end else begin
                            r_ab <= phase_ab(r_state, r_dir_inc);
                        end
`endif
                    end
                end
            endcase
        end
    end

    assign rotary_a = r_ab[1];
    assign rotary_b = r_ab[0];
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_rotary_quadrature_gen.sv
// Directed self-checking bench for rotary_quadrature_gen with an independent x4 quadrature decoder.
module tb_rotary_quadrature_gen;

`ifdef ROTARY_GEN_BOUNCE_EN
    localparam int D = 6;
`else
    localparam int D = 4;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              step_inc;
    logic              step_dec;
    logic              rotary_a;
    logic              rotary_b;
    logic              busy;
    logic signed [3:0] pending;
    logic              overflow;

    int vectors     = 0;
    int miscompares = 0;

    // Decoder model state: position in quarter steps, detent level
    int         pos = 0;
    int         det = 0;
    logic [1:0] dec_prev = 2'b00;
    logic [1:0] dec_cur;

    rotary_quadrature_gen #(.DWELL_CYCLES(D), .PEND_W(4)) dut (
        .clk(clk), .reset(reset), .step_inc(step_inc), .step_dec(step_dec),
        .rotary_a(rotary_a), .rotary_b(rotary_b), .busy(busy),
        .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic int gidx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] seq_ab(input bit inc, input int p);
        case (p)
            0:       return inc ? 2'b01 : 2'b10;
            1:       return 2'b11;
            2:       return inc ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Expected {a,b} at cycle k of a detent (k=0 is the PH1 entry cycle)
    function automatic logic [1:0] exp_ab(input bit inc, input int k);
        int p;
        int j;
        logic [1:0] prv;
        p   = k / D;
        j   = k % D;
        prv = (p == 0) ? 2'b00 : seq_ab(inc, p - 1);
`ifdef ROTARY_GEN_BOUNCE_EN
        if (j == 1 || j == 3) return prv;
`else
        if (j < 0) return prv;
`endif
        return seq_ab(inc, p);
    endfunction

    // Quadrature decoder sampled on the falling edge; illegal two-line jumps to 00 snap back
    initial begin
        forever begin
            @(negedge clk);
            dec_cur = {rotary_a, rotary_b};
            if (dec_cur != dec_prev) begin
                if ((dec_cur ^ dec_prev) == 2'b01 || (dec_cur ^ dec_prev) == 2'b10) begin
                    if (((gidx(dec_cur) - gidx(dec_prev)) & 3) == 1) pos = pos + 1;
                    else pos = pos - 1;
                    if (dec_cur == 2'b00) det = pos / 4;
                end else if (dec_cur == 2'b00) begin
                    pos = det * 4;
                end
                dec_prev = dec_cur;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; step_inc = 1'b0; step_dec = 1'b0;
        tick(); tick();
        vectors++;
        if ({rotary_a, rotary_b} !== 2'b00) begin
            miscompares++; $display("FAIL reset_ab: got %b want 00", {rotary_a, rotary_b});
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++;
        if (pending !== 4'sd0) begin miscompares++; $display("FAIL reset_pending: got %0d want 0", pending); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        reset = 1'b0;
        tick();
    endtask

    task automatic run_detent(input bit inc, input string nm);
        int lvl0;
        lvl0 = det;
        if (inc) step_inc = 1'b1; else step_dec = 1'b1;
        tick();
        step_inc = 1'b0; step_dec = 1'b0;
        vectors++;
        if (pending !== 4'(inc ? 1 : -1) || busy !== 1'b0) begin
            miscompares++; $display("FAIL %s_queued: pending %0d busy %b want %0d/0", nm, pending, busy, inc ? 1 : -1);
        end
        tick();
        for (int k = 0; k < 4 * D; k++) begin
            vectors++;
            if ({rotary_a, rotary_b} !== exp_ab(inc, k) || busy !== 1'b1 || pending !== 4'sd0) begin
                miscompares++;
                $display("FAIL %s_cycle%0d: ab %b busy %b pending %0d want %b/1/0", nm, k,
                         {rotary_a, rotary_b}, busy, pending, exp_ab(inc, k));
            end
            tick();
        end
        vectors++;
        if ({rotary_a, rotary_b} !== 2'b00 || busy !== 1'b0) begin
            miscompares++; $display("FAIL %s_end: ab %b busy %b want 00/0", nm, {rotary_a, rotary_b}, busy);
        end
        tick();
        vectors++;
        if (det !== lvl0 + (inc ? 1 : -1)) begin
            miscompares++; $display("FAIL %s_level: got %0d want %0d", nm, det, lvl0 + (inc ? 1 : -1));
        end
    endtask

    task automatic test_inc_detent;
        run_detent(1'b1, "inc");
    endtask

    task automatic test_dec_detent;
        run_detent(1'b0, "dec");
    endtask

    task automatic test_back_to_back;
        int lvl0;
        int busy_cnt;
        int rises;
        int idle_run;
        bit prev_busy;
        lvl0 = det;
        step_inc = 1'b1;
        tick();
        vectors++;
        if (pending !== 4'sd1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL b2b_p1: pending %0d busy %b want 1/0", pending, busy);
        end
        tick();
        vectors++;
        if (pending !== 4'sd1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL b2b_p2: pending %0d busy %b want 1/1", pending, busy);
        end
        tick();
        step_inc = 1'b0;
        vectors++;
        if (pending !== 4'sd2) begin miscompares++; $display("FAIL b2b_p3: pending %0d want 2", pending); end
        busy_cnt = 2; rises = 1; idle_run = 0; prev_busy = 1'b1;
        for (int n = 0; n < 12 * D + 20; n++) begin
            tick();
            if (busy) begin
                busy_cnt++;
                if (!prev_busy) begin
                    rises++;
                    vectors++;
                    if (idle_run != 1) begin
                        miscompares++; $display("FAIL b2b_gap: got %0d idle cycles want 1", idle_run);
                    end
                end
                idle_run = 0;
            end else begin
                idle_run++;
                vectors++;
                if ({rotary_a, rotary_b} !== 2'b00) begin
                    miscompares++; $display("FAIL b2b_idle_ab: got %b want 00", {rotary_a, rotary_b});
                end
            end
            prev_busy = busy;
        end
        vectors++;
        if (busy_cnt != 12 * D || rises != 3) begin
            miscompares++; $display("FAIL b2b_busy: %0d cycles %0d detents want %0d/3", busy_cnt, rises, 12 * D);
        end
        vectors++;
        if (pending !== 4'sd0 || det !== lvl0 + 3) begin
            miscompares++; $display("FAIL b2b_level: pending %0d level %0d want 0/%0d", pending, det, lvl0 + 3);
        end
    endtask

    task automatic test_cancel;
        int lvl0;
        lvl0 = det;
        step_inc = 1'b1; step_dec = 1'b1;
        tick();
        step_inc = 1'b0; step_dec = 1'b0;
        vectors++;
        if (pending !== 4'sd0 || overflow !== 1'b0) begin
            miscompares++; $display("FAIL cancel_pending: pending %0d ovf %b want 0/0", pending, overflow);
        end
        for (int n = 0; n < 2 * D; n++) begin
            tick();
            vectors++;
            if (busy !== 1'b0 || {rotary_a, rotary_b} !== 2'b00 || pending !== 4'sd0) begin
                miscompares++; $display("FAIL cancel_quiet: busy %b ab %b pending %0d want 0/00/0",
                                        busy, {rotary_a, rotary_b}, pending);
            end
        end
        vectors++;
        if (det !== lvl0) begin miscompares++; $display("FAIL cancel_level: got %0d want %0d", det, lvl0); end
    endtask

    task automatic test_saturate;
        int lvl0;
        bit done;
        lvl0 = det;
        step_inc = 1'b1;
        tick();
        step_inc = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL sat_busy: got %b want 1", busy); end
        for (int k = 1; k <= 9; k++) begin
            step_inc = 1'b1;
            tick();
            vectors++;
            if (pending !== 4'(k > 7 ? 7 : k) || overflow !== (k >= 8)) begin
                miscompares++; $display("FAIL sat_req%0d: pending %0d ovf %b want %0d/%0d",
                                        k, pending, overflow, k > 7 ? 7 : k, k >= 8);
            end
        end
        step_inc = 1'b0;
        tick();
        vectors++;
        if (pending !== 4'sd7 || overflow !== 1'b0) begin
            miscompares++; $display("FAIL sat_hold: pending %0d ovf %b want 7/0", pending, overflow);
        end
        done = 1'b0;
        for (int n = 0; n < 8 * (4 * D + 1) + 20 && !done; n++) begin
            tick();
            if (!busy && pending === 4'sd0) done = 1'b1;
        end
        tick();
        vectors++;
        if (!done || det !== lvl0 + 8) begin
            miscompares++; $display("FAIL sat_drain: done %0d level %0d want 1/%0d", done, det, lvl0 + 8);
        end
    endtask

    task automatic test_reset_mid;
        int lvl0;
        lvl0 = det;
        step_inc = 1'b1;
        tick(); tick(); tick();
        step_inc = 1'b0;
        vectors++;
        if (pending !== 4'sd2) begin miscompares++; $display("FAIL rmid_queue: pending %0d want 2", pending); end
        for (int n = 0; n < D + 1; n++) tick();
        vectors++;
        if ({rotary_a, rotary_b} !== 2'b11 || busy !== 1'b1) begin
            miscompares++; $display("FAIL rmid_ph2: ab %b busy %b want 11/1", {rotary_a, rotary_b}, busy);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({rotary_a, rotary_b} !== 2'b00 || busy !== 1'b0 || pending !== 4'sd0 || overflow !== 1'b0) begin
            miscompares++; $display("FAIL rmid_abort: ab %b busy %b pending %0d ovf %b want 00/0/0/0",
                                    {rotary_a, rotary_b}, busy, pending, overflow);
        end
        reset = 1'b0;
        for (int n = 0; n < 3 * D; n++) begin
            tick();
            vectors++;
            if ({rotary_a, rotary_b} !== 2'b00 || busy !== 1'b0 || pending !== 4'sd0) begin
                miscompares++; $display("FAIL rmid_quiet: ab %b busy %b pending %0d want 00/0/0",
                                        {rotary_a, rotary_b}, busy, pending);
            end
        end
        vectors++;
        if (det !== lvl0) begin miscompares++; $display("FAIL rmid_level: got %0d want %0d", det, lvl0); end
    endtask

    initial begin
        reset = 1'b1; step_inc = 1'b0; step_dec = 1'b0;
        test_reset();
        test_inc_detent();
        test_dec_detent();
        test_back_to_back();
        test_cancel();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
